// File: rtl/lsu_mem_if.sv
// lsu_mem_if -- load/store unit between execute and the data-memory bus.
//
// Accepts one load or store from decode/execute. Each access becomes a single
// valid/ready bus request with byte strobes. Load data is aligned and
// sign/zero-extended. The pipeline is stalled until the access completes.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   mem_read, mem_write      access request (write wins if both are set)
//   data_size, data_sign     00 byte / 01 half / 1x word; 0 = sign-extend load
//   addr, wdata              byte address and store data
//   stall                    hold the pipeline while high
//   rdata, done              extended load result; one-cycle completion pulse
//   misaligned               misaligned-access trap flag (0 unless trap enabled)
//   req_*                    bus request channel (valid/ready)
//   rsp_valid, rsp_rdata     bus read response
//
// Build option: define LSU_MISALIGN_TRAP_EN to trap a half access with
// addr[0] set, or a word access with addr[1:0] != 0. A trapped access issues
// no bus request and completes at once with misaligned = 1 and rdata = 0.
// When the option is not defined, the offending low address bits are ignored.

// One byte lane of the store path. It selects the store byte and the strobe
// bit for this lane.
module lsu_mem_if_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] data_size,
  input  logic [1:0] off,
  input  logic [7:0] b_byte,   // wdata[7:0]
  input  logic [7:0] b_half,   // byte of wdata[15:0] for this lane
  input  logic [7:0] b_word,   // byte of wdata for this lane
  output logic [7:0] lane_data,
  output logic       lane_strb
);
  localparam logic HI = (LANE >= 2);

  always_comb begin
    lane_data = b_word;
    lane_strb = 1'b1;
    case (data_size)
      2'b00: begin
        lane_data = b_byte;
        lane_strb = (off == 2'(LANE));
      end
      2'b01: begin
        lane_data = b_half;
        lane_strb = (off[1] == HI);
      end
      default: ;
    endcase
  end
endmodule

module lsu_mem_if #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            data_size,
  input  logic                  data_sign,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_SIZE-1:0]  wdata,
  output logic                  stall,
  output logic [WORD_SIZE-1:0]  rdata,
  output logic                  done,
  output logic                  misaligned,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_we,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [WORD_SIZE-1:0]  req_wdata,
  output logic [3:0]            req_wstrb,
  input  logic                  rsp_valid,
  input  logic [WORD_SIZE-1:0]  rsp_rdata
);
  localparam int NUM_LANES = WORD_SIZE / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t state, state_nxt;

  logic       we_q, sign_q;
  logic [1:0] size_q, off_q;
  logic       start, trap;

  logic [NUM_LANES-1:0][7:0] st_data;
  logic [NUM_LANES-1:0]      st_strb;
  logic [WORD_SIZE-1:0]      ld_ext;

  assign start = mem_read | mem_write;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal_q;
  assign trap = ((data_size == 2'b01) && addr[0]) ||
                (data_size[1] && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Store-lane steering, one instance per byte lane.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_mem_if_lane #(.LANE(i)) u_lane (
      .data_size (data_size),
      .off       (addr[1:0]),
      .b_byte    (wdata[7:0]),
      .b_half    (wdata[8*(i%2) +: 8]),
      .b_word    (wdata[8*i +: 8]),
      .lane_data (st_data[i]),
      .lane_strb (st_strb[i])
    );
  end

  // Load extract/extend. The latched offset and size are used because the
  // pipeline inputs may already have moved on.
  logic [WORD_SIZE-1:0] sh_b, sh_h;
  logic [7:0]           ld_b;
  logic [15:0]          ld_h;

  always_comb begin
    sh_b   = rsp_rdata >> {off_q, 3'b000};
    sh_h   = rsp_rdata >> {off_q[1], 4'b0000};
    ld_b   = sh_b[7:0];
    ld_h   = sh_h[15:0];
    ld_ext = rsp_rdata;
    case (size_q)
      2'b00:   ld_ext = {{(WORD_SIZE-8){~sign_q & ld_b[7]}}, ld_b};
      2'b01:   ld_ext = {{(WORD_SIZE-16){~sign_q & ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

  // The bus fields are registered when the access is accepted. This holds
  // them stable for the whole REQ phase, whatever the pipeline drives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      sign_q    <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      rdata     <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misal_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        we_q      <= mem_write;
        sign_q    <= data_sign;
        size_q    <= data_size;
        off_q     <= addr[1:0];
        req_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
        req_wdata <= st_data;
        req_wstrb <= mem_write ? st_strb : '0;
`ifdef LSU_MISALIGN_TRAP_EN
        misal_q   <= trap;
        if (trap) rdata <= '0;
`endif
      end
      if (state == WAIT_RSP && rsp_valid) rdata <= ld_ext;
    end
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    req_we    = 1'b0;
    done      = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = start;
        if (start) state_nxt = trap ? DONE : REQ;
      end
      REQ: begin
        stall     = 1'b1;
        req_valid = 1'b1;
        req_we    = we_q;
        if (req_ready) state_nxt = we_q ? DONE : WAIT_RSP;
      end
      WAIT_RSP: begin
        stall = 1'b1;
        if (rsp_valid) state_nxt = DONE;
      end
      DONE: begin
        // stall stays low here so the pipeline retires this access and the
        // same request is not issued a second time.
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (state == DONE) && misal_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule
